// File: rtl/fetch_queue.sv
// Instruction prefetch queue between instruction memory and IF/ID.
// Owns the fetch PC, buffers {pc, instr} pairs, flushes on redirect.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [15:0]   im_addr,
  output logic          im_rd_en,
  input  logic [15:0]   im_data,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  output logic          id_valid,
  output logic [15:0]   id_instr,
  output logic [15:0]   id_pc,
  output logic [CW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   fetch_pc;
  logic [15:0]   inflight_pc;
  logic          inflight;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   buf_pc    [DEPTH];
  logic [15:0]   buf_instr [DEPTH];

  logic          push;
  logic          pop;
  logic          issue;
  logic [CW:0]   occ;

  assign id_valid = (count != '0);
  assign pop      = id_valid & ~stall & ~redirect;
  assign push     = inflight & ~redirect;

  // The in-flight read already owns a slot, so it counts as occupied.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = ~rst & ~redirect & (occ < (CW+1)'(DEPTH));

  assign im_rd_en = issue;
  assign im_addr  = fetch_pc;
  assign level    = count;
  assign id_pc    = id_valid ? buf_pc[rd_ptr]    : 16'h0000;
  assign id_instr = id_valid ? buf_instr[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else if (redirect) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
      fetch_pc <= redirect_pc;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc    <= fetch_pc + 16'd1;
        inflight_pc <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= inflight_pc;
      buf_instr[wr_ptr] <= im_data;
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && !pop && count == CW'(DEPTH))
  );

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue that sits between the instruction memory and the IF/ID boundary of the 5-stage pipeline. It owns the fetch PC, issues one read per cycle to the 1-cycle-latency instruction memory, and buffers returned instructions with their PCs. It presents one instruction per cycle to decode, holds on hazard stalls, and flushes all buffered and in-flight fetches on a taken branch or jump redirect.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 16'h0000, fetch PC loaded on reset
- CW, $clog2(DEPTH)+1, width of count/level signals (derived)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- im_addr  out  16  instruction memory word address (= fetch_pc register)
- im_rd_en  out  1  read request this cycle
- im_data  in  16  read data, valid the cycle after the request
- stall  in  1  decode cannot accept (hazard); no pop this cycle
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  16  new fetch address, sampled when redirect=1
- id_valid  out  1  id_instr/id_pc hold a real instruction
- id_instr  out  16  queue head instruction; 16'h0000 (NOP) when id_valid=0
- id_pc  out  16  PC of queue head; 16'h0000 when id_valid=0
- level  out  CW  number of valid entries

## Operation
- State: fetch_pc (16b), circular buffer of DEPTH {pc, instr} entries, rd_ptr/wr_ptr (log2 DEPTH bits, wrap mod DEPTH), count (CW), inflight (1b), inflight_pc (16b).
- pop = id_valid & ~stall & ~redirect.
- issue = ~redirect & (count + inflight − pop < DEPTH); im_rd_en = issue; im_addr = fetch_pc.
- On issue: fetch_pc <= fetch_pc + 1 (wraps FFFF→0000); inflight <= 1; inflight_pc <= fetch_pc. Otherwise inflight <= 0.
- On inflight=1 and no redirect: write {inflight_pc, im_data} at wr_ptr, wr_ptr++.
- On pop: rd_ptr++. count updates by push−pop; simultaneous push and pop leaves count unchanged.
- id_valid = (count != 0); id_instr/id_pc are the rd_ptr entry, forced to 0 when empty.
- Redirect (highest priority): count <= 0, rd_ptr <= wr_ptr, inflight <= 0, the returning im_data is discarded, fetch_pc <= redirect_pc, no request and no pop that cycle.
- Overflow is impossible by construction (inflight reserves a slot). A push while full is a design error; an assertion flags it.
- stall only blocks pop; fetching continues until the queue plus in-flight reaches DEPTH.

## Timing
- Reset (async): fetch_pc=RESET_PC, count=0, pointers=0, inflight=0. Outputs during and after reset: im_rd_en=0 while rst=1, id_valid=0, id_instr=0, id_pc=0, level=0, im_addr=RESET_PC.
- Cycle 1 after rst release: request RESET_PC. Cycle 2: data returned and written. Cycle 3: id_valid=1. Cold-start latency is 3 cycles.
- Steady state with stall=0: one instruction per cycle, level stays ≤2, no bubbles.
- Redirect at cycle t: request redirect_pc at t+1, id_valid at t+3. id_valid is 0 at t+1 and t+2. The old head is not popped at t.
- Redirect while stall=1: redirect wins and the queue flushes.
- Reset mid-operation: all state returns to its reset values immediately. Data returned after the reset is ignored.

## Test plan
- IM model returns instr = addr ^ 16'hA000. Reset with RESET_PC=0 -> id_valid first high at cycle 3; id_pc 0,1,2,3 on consecutive cycles with id_instr A000,A001,A002,A003.
- stall held high for 8 cycles from steady state -> level rises to 4, im_rd_en drops to 0, head is unchanged. On release, pops resume with no skipped or duplicated PCs.
- redirect to 16'h0040 while 1 request is in flight and 3 entries are queued -> level=0 next cycle, stale data dropped, next valid is id_pc=0040/id_instr=A040 exactly 3 cycles after the redirect.
- redirect_pc=16'hFFFE -> id_pc sequence FFFE, FFFF, 0000, 0001.
- redirect and stall asserted in the same cycle with the queue full -> flush occurs, no pop, refetch from redirect_pc.
- rst pulsed mid-stream with 2 entries queued and 1 in flight -> all outputs go to 0 asynchronously. The restart sequence begins at RESET_PC with no stale entry ever appearing on id_*.
